pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_gen.sv | 160 ++++++++++++++++
 tb/tb_pattern_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// Serial pattern generator: sends a latched pattern MSB-first rep_cnt times with
// gap_cyc idle cycles between repetitions, under valid/ready flow control.
module pattern_gen #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pat_in,
   input  logic [LEN_W-1:0] pat_len,
   input  logic [CNT_W-1:0] rep_cnt,
   input  logic [CNT_W-1:0] gap_cyc,
   input  logic             ready_in,
   output logic             d_out,
   output logic             valid_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
   localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   state_t           state;
   logic [PAT_W-1:0] pat_r;
   logic [LEN_W-1:0] len_r;
   logic [LEN_W-1:0] bit_idx;
   logic [CNT_W-1:0] rep_left;
   logic [CNT_W-1:0] gap_r;
   logic [CNT_W-1:0] gap_left;
   logic [LEN_W-1:0] start_len;

   function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
      if (l == '0 || l > MAX_LEN)
         return MAX_LEN;
      return l;
   endfunction

   // Index via compare loop so an out-of-range index can never select past the pattern.
   function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] idx);
      logic b;
      b = 1'b0;
      for (int i = 0; i < PAT_W; i++)
         if (idx == LEN_W'(i))
            b = p[i];
      return b;
   endfunction

   assign start_len = eff_len(pat_len);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         pat_r     <= '0;
         len_r     <= '0;
         bit_idx   <= '0;
         rep_left  <= '0;
         gap_r     <= '0;
         gap_left  <= '0;
         d_out     <= 1'b0;
         valid_out <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done      <= 1'b0;
               d_out     <= 1'b0;
               valid_out <= 1'b0;
               busy      <= 1'b0;
               if (start) begin
                  pat_r    <= pat_in;
                  len_r    <= start_len;
                  rep_left <= rep_cnt;
                  gap_r    <= gap_cyc;
                  busy     <= 1'b1;
                  if (rep_cnt == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state     <= SEND;
                     bit_idx   <= start_len - ONE_LEN;
                     valid_out <= 1'b1;
                     d_out     <= bit_at(pat_in, start_len - ONE_LEN);
                  end
               end
            end

            SEND: begin
               if (ready_in) begin
                  if (bit_idx == '0) begin
                     rep_left <= rep_left - ONE_CNT;
                     if (rep_left == ONE_CNT) begin
                        state     <= FIN;
                        done      <= 1'b1;
                        valid_out <= 1'b0;
                        d_out     <= 1'b0;
                     end else if (gap_r == '0) begin
                        bit_idx <= len_r - ONE_LEN;
                        d_out   <= bit_at(pat_r, len_r - ONE_LEN);
                     end else begin
                        state     <= GAP;
                        gap_left  <= gap_r;
                        valid_out <= 1'b0;
                        d_out     <= 1'b0;
                     end
                  end else begin
                     bit_idx <= bit_idx - ONE_LEN;
                     d_out   <= bit_at(pat_r, bit_idx - ONE_LEN);
                  end
               end
            end

            GAP: begin
               if (gap_left == ONE_CNT) begin
                  state     <= SEND;
                  gap_left  <= '0;
                  bit_idx   <= len_r - ONE_LEN;
                  valid_out <= 1'b1;
                  d_out     <= bit_at(pat_r, len_r - ONE_LEN);
               end else begin
                  gap_left <= gap_left - ONE_CNT;
               end
            end

            FIN: begin
               state     <= IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
               valid_out <= 1'b0;
               d_out     <= 1'b0;
               bit_idx   <= '0;
               rep_left  <= '0;
               gap_left  <= '0;
            end

            default: begin
               state     <= IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
               valid_out <= 1'b0;
               d_out     <= 1'b0;
               bit_idx   <= '0;
               rep_left  <= '0;
               gap_left  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: token-stream reference model with a per-cycle compare,
// directed scenarios with literal expectations, then randomized bursts.
module tb_pattern_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] pat_in;
   logic [3:0] pat_len;
   logic [7:0] rep_cnt;
   logic [7:0] gap_cyc;
   logic       ready_in;
   logic       d_out, valid_out, busy, done;

   pattern_gen #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .pat_in(pat_in), .pat_len(pat_len),
      .rep_cnt(rep_cnt), .gap_cyc(gap_cyc), .ready_in(ready_in),
      .d_out(d_out), .valid_out(valid_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference: queue of what each upcoming cycle shows. 0/1 = data bit, 2 = gap, 3 = done.
   int q[$];
   int cyc = 0;
   bit chk_en = 1'b0;

   int rx[$];
   int rx_cyc[$];
   int done_cnt = 0;
   int done_cyc = 0;
   int busy_cnt = 0;

   int rdy_mode = 0;
   int rdy_i = 0;
   bit start_noise = 1'b0;
   int rdy_seq[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_burst(input logic [7:0] p, input logic [3:0] l, input logic [7:0] r, input logic [7:0] g);
      int len;
      logic [7:0] t;
      len = (l == 0 || l > 8) ? 8 : int'(l);
      for (int k = 0; k < int'(r); k++) begin
         for (int i = len - 1; i >= 0; i--) begin
            t = p >> i;
            q.push_back(int'(t[0]));
         end
         if (k < int'(r) - 1)
            for (int j = 0; j < int'(g); j++) q.push_back(2);
      end
      q.push_back(3);
   endtask

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         q.delete();
         chk_en = 1'b1;
      end else if (q.size() == 0) begin
         if (start) push_burst(pat_in, pat_len, rep_cnt, gap_cyc);
      end else if (q[0] <= 1) begin
         if (ready_in) void'(q.pop_front());
      end else begin
         void'(q.pop_front());
      end
   end

   always @(negedge clk) begin
      logic [3:0] exp;
      if (chk_en) begin
         if (q.size() == 0)     exp = 4'b0000;
         else if (q[0] == 2)    exp = 4'b1000;
         else if (q[0] == 3)    exp = 4'b1001;
         else                   exp = {2'b11, q[0][0], 1'b0};
         chk("outs{busy,valid,d,done}", {60'd0, busy, valid_out, d_out, done}, {60'd0, exp});
         if (valid_out && ready_in) begin
            rx.push_back(int'(d_out));
            rx_cyc.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (busy && !done) busy_cnt++;
      end
   end

   function automatic logic [63:0] rx_val();
      logic [63:0] v;
      v = '0;
      foreach (rx[i]) v = (v << 1) | 64'(rx[i]);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      case (rdy_mode)
         0: ready_in = 1'b1;
         1: begin ready_in = rdy_seq[rdy_i % 4][0]; rdy_i++; end
         default: ready_in = ($urandom_range(0, 3) != 0);
      endcase
      if (start_noise) start = busy ? ($urandom_range(0, 5) == 0) : 1'b0;
   endtask

   int s_cyc;

   task automatic do_start(input logic [7:0] p, input logic [3:0] l, input logic [7:0] r, input logic [7:0] g);
      pat_in = p; pat_len = l; rep_cnt = r; gap_cyc = g;
      start = 1'b1;
      s_cyc = cyc;
      tick();
      start = 1'b0;
      pat_in = 8'($urandom); pat_len = 4'($urandom); rep_cnt = 8'($urandom); gap_cyc = 8'($urandom);
   endtask

   task automatic wait_done(input int limit);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < limit && done_cnt == d0; i++) tick();
      if (done_cnt == d0) chk("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_idle(input int limit);
      for (int i = 0; i < limit && busy; i++) tick();
      if (busy) chk("idle_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      int d0;
      int first2;
      rdy_seq[0] = 1; rdy_seq[1] = 0; rdy_seq[2] = 0; rdy_seq[3] = 1;
      rst = 1'b0; start = 1'b0; ready_in = 1'b1;
      pat_in = '0; pat_len = '0; rep_cnt = '0; gap_cyc = '0;
      tick(); tick();
      chk("reset_outs", {60'd0, busy, valid_out, d_out, done}, 64'd0);
      rst = 1'b1;
      tick();

      // Single repetition, pattern in low 4 bits
      rx.delete(); rx_cyc.delete();
      do_start(8'b0000_1011, 4'd4, 8'd1, 8'd0);
      wait_done(50);
      chk("t1_bits", rx_val(), 64'hB);
      chk("t1_count", 64'(rx.size()), 64'd4);
      chk("t1_first_cyc", 64'(rx_cyc[0]), 64'(s_cyc + 1));
      chk("t1_last_cyc", 64'(rx_cyc[3]), 64'(s_cyc + 4));
      chk("t1_done_cyc", 64'(done_cyc), 64'(s_cyc + 5));
      chk("t1_busy_after", {63'd0, busy}, 64'd0);

      // Three repetitions with two-cycle gaps
      tick();
      rx.delete(); busy_cnt = 0;
      do_start(8'b0000_0101, 4'd3, 8'd3, 8'd2);
      wait_done(100);
      chk("t2_bits", rx_val(), 64'h16D);
      chk("t2_count", 64'(rx.size()), 64'd9);
      chk("t2_busy_cycles", 64'(busy_cnt), 64'd13);

      // Stalls from ready_in pattern 1,0,0,1
      tick();
      rx.delete(); rdy_mode = 1; rdy_i = 0;
      do_start(8'h0D, 4'd4, 8'd1, 8'd0);
      wait_done(100);
      chk("t3_bits", rx_val(), 64'hD);
      chk("t3_count", 64'(rx.size()), 64'd4);
      rdy_mode = 0;

      // Zero repetitions, then length 0 meaning full width
      tick();
      rx.delete();
      do_start(8'hFF, 4'd4, 8'd0, 8'd0);
      wait_done(20);
      chk("t4_no_valid", 64'(rx.size()), 64'd0);
      chk("t4_done_cyc", 64'(done_cyc), 64'(s_cyc + 1));
      tick();
      rx.delete();
      do_start(8'hA5, 4'd0, 8'd1, 8'd0);
      wait_done(50);
      chk("t4_len0_bits", rx_val(), 64'hA5);
      chk("t4_len0_count", 64'(rx.size()), 64'd8);

      // Reset after two transfers aborts the burst without done
      tick();
      rx.delete(); d0 = done_cnt;
      do_start(8'h0D, 4'd4, 8'd1, 8'd0);
      tick(); tick();
      chk("t5_pre_reset_count", 64'(rx.size()), 64'd2);
      rst = 1'b0;
      tick();
      chk("t5_reset_outs", {60'd0, busy, valid_out, d_out, done}, 64'd0);
      rst = 1'b1;
      tick(); tick();
      chk("t5_no_done", 64'(done_cnt), 64'(d0));
      rx.delete();
      do_start(8'h0D, 4'd4, 8'd1, 8'd0);
      wait_done(50);
      chk("t5_fresh_bits", rx_val(), 64'hD);

      // start held high: back-to-back bursts with one idle cycle
      tick();
      rx.delete(); rx_cyc.delete();
      pat_in = 8'h05; pat_len = 4'd3; rep_cnt = 8'd1; gap_cyc = 8'd0;
      start = 1'b1;
      wait_done(50);
      first2 = done_cyc + 2;
      wait_done(50);
      start = 1'b0;
      chk("t6_second_start", 64'(rx_cyc[3]), 64'(first2));
      chk("t6_total_bits", rx_val(), 64'h2D);
      wait_idle(20);

      // start pulse during SEND must not queue a burst
      tick();
      d0 = done_cnt;
      do_start(8'h0A, 4'd4, 8'd2, 8'd1);
      tick(); tick();
      start = 1'b1; tick(); start = 1'b0;
      wait_done(50);
      repeat (6) tick();
      chk("t6_single_done", 64'(done_cnt), 64'(d0 + 1));

      // Maximum repetition count
      tick();
      rx.delete(); rdy_mode = 2;
      do_start(8'h02, 4'd2, 8'd255, 8'd0);
      wait_done(3000);
      chk("max_rep_count", 64'(rx.size()), 64'd510);

      // Randomized bursts with random ready and ignored start noise
      for (int n = 0; n < 40; n++) begin
         wait_idle(50);
         tick();
         rx.delete();
         start_noise = 1'b0;
         do_start(8'($urandom), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 4)),
                  8'($urandom_range(0, 3)));
         start_noise = 1'b1;
         wait_done(400);
         start_noise = 1'b0;
         start = 1'b0;
      end
      wait_idle(50);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
